reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//  Architectural register file with rename tags for the Tomasulo core. Sink of the
//  ROB's commit/rename stream (set_*) and operand source for the decoder. Holds 32x32b
//  values plus a per-register ROB dependency tag, and resolves operands through the
//  ROB value lookup ports (get_rob_id_*). x0 is hardwired to zero.
// PARAMETERS
//  ROB_W    4   ROB index width in bits (2**ROB_W entries); width of every ROB id port
// PORTS
//  clk_in           in   1      clock; all state updates on rising edge
//  rst_in           in   1      reset, asynchronous, active-high
//  rdy_in           in   1      0 = hold all state; reads stay combinational
//  rob_clear        in   1      flush: drop every dependency tag
//  set_id           in   5      commit target reg; 0 = no commit
//  set_val          in   32     commit value
//  set_from_rob_id  in   ROB_W  ROB id of the committing entry
//  set_dep_id       in   5      reg renamed by the newly issued instr; 0 = none
//  set_dep_Q        in   ROB_W  ROB id that will produce set_dep_id
//  rs1_id, rs2_id   in   5      decoder source register ids
//  rs1_val, rs2_val out  32     operand value (0 while still dependent)
//  rs1_dep, rs2_dep out  1      1 = operand not ready, wait on rs*_Q
//  rs1_Q, rs2_Q     out  ROB_W  producer ROB id (0 when rs*_dep = 0)
//  get_rob_id_1/2   out  ROB_W  = current tag of rs1/rs2, for the ROB lookup
//  rob_avail_1/2    in   1      ROB entry is done and holds a value
//  rob_val_1/2      in   32     that value
// BEHAVIOUR
//  State: val[0..31] (32b), busy[0..31] (1b), Q[0..31] (ROB_W).
//  Reset (async): all val = 0, busy = 0, Q = 0, so every read output is 0.
//  Each rising edge with rdy_in=1 applies, in order:
//   1 commit: if set_id != 0, val[set_id] <= set_val; additionally, if busy[set_id]
//     and Q[set_id] == set_from_rob_id, busy <= 0. A tag mismatch means a younger
//     rename exists, so the tag is kept.
//   2 rename: if set_dep_id != 0 and !rob_clear, busy[set_dep_id] <= 1 and
//     Q[set_dep_id] <= set_dep_Q. This overrides the step-1 clear on the same reg.
//   3 flush: if rob_clear, busy[*] <= 0 for all regs. Values are kept, and the
//     same-cycle commit value is still written.
//  rdy_in=0: no state change; commit/rename inputs that cycle are ignored.
//  Read port n (combinational, 0-cycle latency, from pre-edge state), first match wins:
//   rsn_id == 0                               -> val 0, dep 0, Q 0
//   !busy[r]                                  -> val[r], dep 0, Q 0
//   set_id==r && set_from_rob_id==Q[r]        -> set_val, dep 0 (commit bypass)
//   rob_avail_n                               -> rob_val_n, dep 0 (ROB forward)
//   otherwise                                 -> val 0, dep 1, Q = Q[r]
//  get_rob_id_n = Q[rsn_id] always, with no gating.
//  A source read never sees the same-cycle rename of the issuing instr's own rd
//  (e.g. add x5,x5,x1 reads x5's old state).
//  Writes to x0 through set_id or set_dep_id are discarded. busy[0] stays 0.
//  The ROB id is used modulo 2**ROB_W with no wrap logic needed; tags compare by equality only.
// TESTING
//  T1 reset mid-run with busy regs -> all rs* outputs 0, busy cleared, without waiting for clock.
//  T2 rename x3->Q=5, then read rs1=3 with rob_avail_1=0 -> dep=1, Q=5, get_rob_id_1=5;
//     with rob_avail_1=1, rob_val_1=0x77 -> val=0x77, dep=0.
//  T3 rename x3->Q5, later x3->Q9; commit x3 from Q5 with 0x11 -> val[3]=0x11, busy kept,
//     Q=9; commit from Q9 with 0x22 -> busy cleared, read 0x22.
//  T4 same edge: commit x4 (Q2, 0xAA) and rename x4->Q6 -> val[4]=0xAA, busy=1, Q=6;
//     same-cycle read of x4 -> 0xAA via commit bypass, dep=0.
//  T5 rob_clear with 3 busy regs and a same-cycle rename x7->Q1 -> no busy bits set,
//     x7 not busy, committed value written.
//  T6 set_id=0 / set_dep_id=0 with nonzero data, and rdy_in=0 with valid commit ->
//     no state change; rs1_id=0 always reads 0, dep 0.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags (32 x 32b, x0 = 0).
// Latency: operand reads are combinational (0 cycles) from pre-edge state; updates land on the clock edge.
// Backpressure: rdy_in=0 freezes all state and ignores commit/rename inputs; reads keep working.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in   - clock, reset, global stall
//   rob_clear                                     - flush: drop every dependency tag
//   set_id/set_val/set_from_rob_id                - commit stream from the ROB (set_id=0: none)
//   set_dep_id/set_dep_Q                          - rename of a newly issued rd (set_dep_id=0: none)
//   rs1_id/rs2_id -> rs*_val/rs*_dep/rs*_Q        - decoder operand lookup
//   get_rob_id_1/2, rob_avail_1/2, rob_val_1/2    - ROB value lookup for still-renamed operands
module reg_file #(
   parameter int ROB_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             rob_clear,
   input  logic [4:0]       set_id,
   input  logic [31:0]      set_val,
   input  logic [ROB_W-1:0] set_from_rob_id,
   input  logic [4:0]       set_dep_id,
   input  logic [ROB_W-1:0] set_dep_Q,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   output logic [31:0]      rs1_val,
   output logic [31:0]      rs2_val,
   output logic             rs1_dep,
   output logic             rs2_dep,
   output logic [ROB_W-1:0] rs1_Q,
   output logic [ROB_W-1:0] rs2_Q,
   output logic [ROB_W-1:0] get_rob_id_1,
   output logic [ROB_W-1:0] get_rob_id_2,
   input  logic             rob_avail_1,
   input  logic             rob_avail_2,
   input  logic [31:0]      rob_val_1,
   input  logic [31:0]      rob_val_2
);

   logic [31:0]      val_q  [32];
   logic [31:0]      val_d  [32];
   logic [31:0]      busy_q;
   logic [31:0]      busy_d;
   logic [ROB_W-1:0] tag_q  [32];
   logic [ROB_W-1:0] tag_d  [32];

   // Next state: commit, then rename, then flush. Later steps win on the same register.
   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (set_id != 5'd0) begin
         val_d[set_id] = set_val;
         // Only the youngest rename may release the register; an older commit just updates the value.
         if (busy_q[set_id] && (tag_q[set_id] == set_from_rob_id)) begin
            busy_d[set_id] = 1'b0;
         end
      end
      if ((set_dep_id != 5'd0) && !rob_clear) begin
         busy_d[set_dep_id] = 1'b1;
         tag_d[set_dep_id]  = set_dep_Q;
      end
      // Flush drops dependencies only; tags are left stale since busy=0 masks them.
      if (rob_clear) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < 32; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_q <= '0;
      end else if (rdy_in) begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

   // Two identical read ports, handled as a small array so the priority chain is written once.
   logic [4:0]       rd_id    [2];
   logic             rd_avail [2];
   logic [31:0]      rd_rob   [2];
   logic [31:0]      rd_val   [2];
   logic             rd_dep   [2];
   logic [ROB_W-1:0] rd_q     [2];

   always_comb begin
      rd_id[0]    = rs1_id;
      rd_id[1]    = rs2_id;
      rd_avail[0] = rob_avail_1;
      rd_avail[1] = rob_avail_2;
      rd_rob[0]   = rob_val_1;
      rd_rob[1]   = rob_val_2;
   end

   always_comb begin
      for (int n = 0; n < 2; n++) begin
         rd_val[n] = '0;
         rd_dep[n] = 1'b0;
         rd_q[n]   = '0;
         if (rd_id[n] != 5'd0) begin
            if (!busy_q[rd_id[n]]) begin
               rd_val[n] = val_q[rd_id[n]];
            end else if ((set_id == rd_id[n]) && (set_from_rob_id == tag_q[rd_id[n]])) begin
               // Producer is committing this very cycle: take its value straight off the commit bus.
               rd_val[n] = set_val;
            end else if (rd_avail[n]) begin
               rd_val[n] = rd_rob[n];
            end else begin
               rd_dep[n] = 1'b1;
               rd_q[n]   = tag_q[rd_id[n]];
            end
         end
      end
   end

   assign rs1_val      = rd_val[0];
   assign rs2_val      = rd_val[1];
   assign rs1_dep      = rd_dep[0];
   assign rs2_dep      = rd_dep[1];
   assign rs1_Q        = rd_q[0];
   assign rs2_Q        = rd_q[1];
   // Raw tag, ungated, so the ROB lookup can start before the busy check resolves.
   assign get_rob_id_1 = tag_q[rs1_id];
   assign get_rob_id_2 = tag_q[rs2_id];

endmodule
